// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// load_store_unit_pkg : shared types and fault check for the load/store unit
// Rev 1.0 : initial release
// ============================================================================
package load_store_unit_pkg;

  localparam int LSU_XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } lsu_size_t;

  typedef struct packed {
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
    logic                is_store;
    lsu_size_t           size;
    logic                is_unsigned;
    logic [4:0]          rd;
  } lsu_req_t;

  // Encoding 2'b11 has no enum member and always faults.
  function automatic logic lsu_is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic fault;
    case (size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = offset[0];
      2'b10:   fault = |offset;
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_data_align.sv
`default_nettype none
// ============================================================================
// lsu_data_align : load lane extract/extend and store lane merge
// Rev 1.0 : initial release
// ============================================================================
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]          offset_i,
  input  lsu_size_t           size_i,
  input  logic                is_unsigned_i,
  input  logic [LSU_XLEN-1:0] word_i,
  input  logic [LSU_XLEN-1:0] wdata_i,
  output logic [LSU_XLEN-1:0] load_data_o,
  output logic [LSU_XLEN-1:0] merged_word_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word_i[{offset_i, 3'b000} +: 8];
    half_lane = word_i[{offset_i[1], 4'b0000} +: 16];

    case (size_i)
      SIZE_B:  load_data_o = {{24{~is_unsigned_i & byte_lane[7]}}, byte_lane};
      SIZE_H:  load_data_o = {{16{~is_unsigned_i & half_lane[15]}}, half_lane};
      default: load_data_o = word_i;
    endcase

    // Only the addressed lane is replaced; every other bit of the read word survives.
    merged_word_o = word_i;
    case (size_i)
      SIZE_B:  merged_word_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
      SIZE_H:  merged_word_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_word_o = wdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : byte/half/word loads and stores onto a word-only cache port
// Rev 1.0 : initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  req_is_store_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [4:0]            req_rd_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [4:0]            rsp_rd_o,
  output logic                  rsp_misaligned_o,
  output logic                  dc_valid_o,
  input  logic                  dc_ready_i,
  output logic [DATA_WIDTH-1:0] dc_addr_o,
  output logic                  dc_we_o,
  output logic [DATA_WIDTH-1:0] dc_data_wr_o,
  input  logic [DATA_WIDTH-1:0] dc_data_rd_i
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACCESS    = 3'd1,
    S_RMW_READ  = 3'd2,
    S_RMW_WRITE = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  state_e                state_q, state_d;
  lsu_req_t              req_q, req_d;
  logic                  dc_valid_q, dc_valid_d;
  logic                  dc_we_q, dc_we_d;
  logic [DATA_WIDTH-1:0] dc_wdata_q, dc_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_mis_q, rsp_mis_d;

  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged_word;

  lsu_data_align u_align (
    .offset_i      (req_q.addr[1:0]),
    .size_i        (req_q.size),
    .is_unsigned_i (req_q.is_unsigned),
    .word_i        (dc_data_rd_i),
    .wdata_i       (req_q.wdata),
    .load_data_o   (load_data),
    .merged_word_o (merged_word)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    dc_valid_d  = dc_valid_q;
    dc_we_d     = dc_we_q;
    dc_wdata_d  = dc_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_mis_d   = rsp_mis_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          req_d.addr        = req_addr_i;
          req_d.wdata       = req_wdata_i;
          req_d.is_store    = req_is_store_i;
          req_d.size        = lsu_size_t'(req_size_i);
          req_d.is_unsigned = req_unsigned_i;
          req_d.rd          = req_rd_i;
          rsp_data_d        = '0;
          rsp_mis_d         = 1'b0;
          if (lsu_is_misaligned(req_size_i, req_addr_i[1:0])) begin
            rsp_mis_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else if (!req_is_store_i) begin
            dc_valid_d = 1'b1;
            state_d    = S_ACCESS;
          end else if (req_size_i == SIZE_W) begin
            dc_valid_d = 1'b1;
            dc_we_d    = 1'b1;
            dc_wdata_d = req_wdata_i;
            state_d    = S_ACCESS;
          end else begin
            dc_valid_d = 1'b1;
            state_d    = S_RMW_READ;
          end
        end
      end
      S_ACCESS: begin
        if (dc_ready_i) begin
          if (!req_q.is_store) rsp_data_d = load_data;
          dc_valid_d  = 1'b0;
          dc_we_d     = 1'b0;
          dc_wdata_d  = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RMW_READ: begin
        if (dc_ready_i) begin
          dc_we_d    = 1'b1;
          dc_wdata_d = merged_word;
          state_d    = S_RMW_WRITE;
        end
      end
      S_RMW_WRITE: begin
        if (dc_ready_i) begin
          dc_valid_d  = 1'b0;
          dc_we_d     = 1'b0;
          dc_wdata_d  = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      dc_valid_q  <= 1'b0;
      dc_we_q     <= 1'b0;
      dc_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      dc_valid_q  <= dc_valid_d;
      dc_we_q     <= dc_we_d;
      dc_wdata_q  <= dc_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mis_q   <= rsp_mis_d;
    end
  end

  // The address comes straight from the latched request, so it cannot move during a stall.
  assign req_ready_o      = (state_q == S_IDLE);
  assign dc_valid_o       = dc_valid_q;
  assign dc_addr_o        = {req_q.addr[DATA_WIDTH-1:2], 2'b00};
  assign dc_we_o          = dc_we_q;
  assign dc_data_wr_o     = dc_wdata_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_rd_o         = req_q.rd;
  assign rsp_misaligned_o = rsp_mis_q;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and the data cache, and turns RISC-V load/store requests (byte, half or word) into word-granular data-cache accesses. The cache port has no byte enables, so sub-word stores are done as read-modify-write. Loads are sign- or zero-extended, misaligned and illegal-size accesses are flagged without touching the cache, and one request is in flight at a time behind valid/ready handshakes on both sides.

## Interface
- DATA_WIDTH, 32, datapath and address width; fixed at 32.
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  execute stage presents a memory request.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned in bits [7:0], [15:0] or [31:0].
- req_is_store_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned_i  in  1  zero-extend loads (LBU/LHU).
- req_rd_i  in  5  destination tag, returned with the response.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i.
- rsp_data_o  out  32  extended load data; 0 for stores and faults.
- rsp_rd_o  out  5  latched req_rd_i.
- rsp_misaligned_o  out  1  misaligned access or illegal size; no cache access is made.
- dc_valid_o  out  1  cache request valid.
- dc_ready_i  in  1  cache accepts (hit); read data is valid in the same cycle.
- dc_addr_o  out  32  word-aligned address {addr[31:2], 2'b00}.
- dc_we_o  out  1  cache write.
- dc_data_wr_o  out  32  cache write word.
- dc_data_rd_i  in  32  cache read word.

## Operation
- States: IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP.
- req_ready_o = (state == IDLE). On acceptance the unit latches addr, wdata, size, unsigned, rd and is_store.
- Fault check at acceptance:
  - half access with addr[0] set, word access with addr[1:0] != 0, or size 11 -> go to RESP with misaligned = 1 and data = 0.
- Next state from IDLE, for a legal request:
  - load (any size) -> ACCESS with we = 0.
  - word store -> ACCESS with we = 1 and data = wdata.
  - byte or half store -> RMW_READ.
- ACCESS: dc_valid_o = 1. On dc_ready_i, a load captures extract(dc_data_rd_i) into rsp_data. Both loads and stores then go to RESP.
- RMW_READ: dc_valid_o = 1, dc_we_o = 0. On dc_ready_i, capture merge(dc_data_rd_i) and go to RMW_WRITE.
- RMW_WRITE: dc_valid_o = 1, dc_we_o = 1, dc_data_wr_o = merged word. On dc_ready_i go to RESP.
- RESP: rsp_valid_o = 1. On rsp_ready_i go to IDLE.
- Load extract:
  - byte = word[8*addr[1:0] +: 8].
  - half = word[16*addr[1] +: 16].
  - sign-extend from the MSB unless unsigned; word passes through.
- Store merge: replace only the addressed byte or half lane with wdata[7:0] or wdata[15:0]; all other bits are preserved.
- dc_we_o and dc_data_wr_o are 0 whenever dc_valid_o = 0.
- While dc_valid_o = 1 and dc_ready_i = 0 (cache miss or writeback), dc_addr_o, dc_we_o and dc_data_wr_o hold stable.

## Timing
- Reset values:
  - state IDLE, so req_ready_o = 1.
  - rsp_valid_o, rsp_misaligned_o, dc_valid_o and dc_we_o = 0.
  - rsp_data_o, rsp_rd_o, dc_addr_o and dc_data_wr_o = 0.
- Acceptance is cycle 0 in all cases below.
- Load or word store with a hit: ACCESS at cycle 1, rsp_valid_o at cycle 2.
- Sub-word store with a hit: RMW_READ at cycle 1, RMW_WRITE at cycle 2, rsp_valid_o at cycle 3.
- Fault: rsp_valid_o at cycle 1; dc_valid_o never rises.
- Each cache miss adds cycles until dc_ready_i rises; there is no timeout.
- rsp_valid_o and all response fields hold until rsp_ready_i. No new request is accepted until the cycle after the response handshake, so there is no back-to-back overlap.
- dc_ready_i is ignored when dc_valid_o = 0.
- Reset mid-operation returns to IDLE immediately and drops dc_valid_o. A partially completed RMW is abandoned: the read has no effect and the write was never issued.

## Structure
- Shared package gets:
  - lsu_size_t enum: SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10.
  - lsu_req_t struct: addr, wdata, is_store, size, unsigned, rd.
- The state enum stays local to the module.
- One combinational sub-module, lsu_data_align, implements load extract/extend and store lane merge. Inputs: offset, size, unsigned, word, wdata. Outputs: load_data, merged_word.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW 0x100, with hits -> one dc write with data 0xDEADBEEF; load rsp_data_o = 0xDEADBEEF at acceptance + 2.
- Memory word at 0x200 = 0x80FF0000 -> LB 0x203 returns 0xFFFFFF80; LBU 0x203 returns 0x00000080; LH 0x202 returns 0xFFFF80FF.
- Word at 0x300 = 0x11223344, SB 0xAA to 0x301 -> read then write of 0x1122AA44; dc_we_o accepted exactly once; rsp at acceptance + 3.
- LH 0x101, SW 0x102 and size 11 -> rsp_misaligned_o = 1, rsp_data_o = 0, dc_valid_o stays 0, rsp at acceptance + 1.
- dc_ready_i held low 10 cycles during SH 0xBEEF to 0x402 -> address, we and data stable throughout; final word upper half = 0xBEEF.
- rsp_ready_i low 3 cycles -> rsp fields held and req_ready_o = 0.
- Reset asserted in RMW_WRITE -> IDLE with dc_valid_o = 0 immediately.
